// File: rtl/gcbp_bram_reader_pkg.sv
`default_nettype none
// ============================================================================
// gcbp_bram_reader_pkg : geometry, frame-location encoding and helpers shared
// by the GCBP line writer and BRAM reader.            Revision: 1.0
// ============================================================================
package gcbp_bram_reader_pkg;

  localparam int C_SUBIMAGE_HEIGHT = 64;
  localparam int C_NUM_SUBIMAGES   = 16;
  localparam int C_DATA_WIDTH      = 128;
  localparam int C_REGION_BITS     = 7;

  localparam int C_LINE_BITS = $clog2(C_SUBIMAGE_HEIGHT);
  localparam int C_SUB_BITS  = $clog2(C_NUM_SUBIMAGES);
  localparam int C_LOC_BITS  = 2;
  localparam int C_ADDR_BITS = C_LOC_BITS + C_REGION_BITS;

  // 2-bit region id selecting one of the four double-buffer frame regions
  typedef logic [C_LOC_BITS-1:0] frame_loc_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_CURR = 3'd1,
    S_RD_PREV = 3'd2,
    S_LOAD    = 3'd3,
    S_DONE    = 3'd4
  } rd_state_t;

  function automatic logic [C_ADDR_BITS-1:0] make_addr(input frame_loc_t loc,
                                                       input logic [C_LINE_BITS-1:0] line);
    return {loc, C_REGION_BITS'(line)};
  endfunction

  function automatic logic [C_NUM_SUBIMAGES-1:0] sub_onehot(input logic [C_SUB_BITS-1:0] sub);
    logic [C_NUM_SUBIMAGES-1:0] v;
    v      = '0;
    v[sub] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gcbp_read_index_counter.sv
`default_nettype none
// ============================================================================
// gcbp_read_index_counter : line/subimage walk counters with wrap and
// last-line / last-beat flags.                        Revision: 1.0
// ============================================================================
module gcbp_read_index_counter
  import gcbp_bram_reader_pkg::*;
(
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_clear,
  input  logic                   i_advance,
  output logic [C_LINE_BITS-1:0] o_line,
  output logic [C_SUB_BITS-1:0]  o_sub,
  output logic [C_LINE_BITS-1:0] o_next_line,
  output logic [C_SUB_BITS-1:0]  o_next_sub,
  output logic                   o_last_line,
  output logic                   o_last
);

  logic [C_LINE_BITS-1:0] r_line;
  logic [C_SUB_BITS-1:0]  r_sub;
  logic                   w_last_line;
  logic                   w_last;
  logic [C_LINE_BITS-1:0] w_next_line;
  logic [C_SUB_BITS-1:0]  w_next_sub;

  always_comb begin
    w_last_line = (r_line == C_LINE_BITS'(C_SUBIMAGE_HEIGHT - 1));
    w_last      = w_last_line && (r_sub == C_SUB_BITS'(C_NUM_SUBIMAGES - 1));
    w_next_line = w_last_line ? '0 : r_line + 1'b1;
    w_next_sub  = r_sub;
    if (w_last_line) begin
      w_next_sub = w_last ? '0 : r_sub + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_line <= '0;
      r_sub  <= '0;
    end else if (i_advance) begin
      r_line <= w_next_line;
      r_sub  <= w_next_sub;
    end
  end

  assign o_line      = r_line;
  assign o_sub       = r_sub;
  assign o_next_line = w_next_line;
  assign o_next_sub  = w_next_sub;
  assign o_last_line = w_last_line;
  assign o_last      = w_last;

endmodule
`default_nettype wire

// File: rtl/gcbp_bram_reader.sv
`default_nettype none
// ============================================================================
// gcbp_bram_reader : walks the 16-BRAM subimage array and emits paired
// current/previous-frame line words over valid/ready.  Revision: 1.0
// ============================================================================
module gcbp_bram_reader
  import gcbp_bram_reader_pkg::*;
(
  input  logic                                      i_clk,
  input  logic                                      i_reset,
  input  logic                                      i_start,
  input  logic [C_LOC_BITS-1:0]                     i_curr_frame_loc,
  input  logic [C_LOC_BITS-1:0]                     i_prev_frame_loc,
  output logic [C_ADDR_BITS-1:0]                    o_bram_array_read_addr,
  output logic [C_NUM_SUBIMAGES-1:0]                o_bram_array_read_enable,
  input  logic [C_NUM_SUBIMAGES*C_DATA_WIDTH-1:0]   i_bram_array_read_data,
  output logic [C_DATA_WIDTH-1:0]                   o_curr_data,
  output logic [C_DATA_WIDTH-1:0]                   o_prev_data,
  output logic [C_SUB_BITS-1:0]                     o_subimage_idx,
  output logic [C_LINE_BITS-1:0]                    o_line_idx,
  output logic                                      o_last_line,
  output logic                                      o_last,
  output logic                                      o_valid,
  input  logic                                      i_ready,
  output logic                                      o_busy,
  output logic                                      o_done
);

  rd_state_t              r_state;
  frame_loc_t             r_curr_loc;
  frame_loc_t             r_prev_loc;
  logic [C_DATA_WIDTH-1:0] r_hold;

  logic [C_LINE_BITS-1:0] w_line;
  logic [C_LINE_BITS-1:0] w_next_line;
  logic [C_SUB_BITS-1:0]  w_sub;
  logic [C_SUB_BITS-1:0]  w_next_sub;
  logic                   w_last_line;
  logic                   w_last;
  logic                   w_cnt_clear;
  logic                   w_cnt_advance;
  logic                   w_out_free;
  logic [C_DATA_WIDTH-1:0] w_words [C_NUM_SUBIMAGES];
  logic [C_DATA_WIDTH-1:0] w_bram_word;

  genvar g;
  generate
    for (g = 0; g < C_NUM_SUBIMAGES; g++) begin : g_split
      assign w_words[g] = i_bram_array_read_data[g*C_DATA_WIDTH +: C_DATA_WIDTH];
    end
  endgenerate

  // Mux on the registered sub counter: the enable bus is already cleared in S_LOAD
  assign w_bram_word   = w_words[w_sub];
  assign w_out_free    = !o_valid || i_ready;
  assign w_cnt_clear   = (r_state == S_IDLE) && i_start;
  assign w_cnt_advance = (r_state == S_LOAD) && w_out_free && !w_last;

  gcbp_read_index_counter u_index (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_clear     (w_cnt_clear),
    .i_advance   (w_cnt_advance),
    .o_line      (w_line),
    .o_sub       (w_sub),
    .o_next_line (w_next_line),
    .o_next_sub  (w_next_sub),
    .o_last_line (w_last_line),
    .o_last      (w_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state                  <= S_IDLE;
      r_curr_loc               <= '0;
      r_prev_loc               <= '0;
      r_hold                   <= '0;
      o_bram_array_read_addr   <= '0;
      o_bram_array_read_enable <= '0;
      o_curr_data              <= '0;
      o_prev_data              <= '0;
      o_subimage_idx           <= '0;
      o_line_idx               <= '0;
      o_last_line              <= 1'b0;
      o_last                   <= 1'b0;
      o_valid                  <= 1'b0;
      o_busy                   <= 1'b0;
      o_done                   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end

      // Address/enable are registered one state ahead so they line up with
      // the state that owns the read.
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_curr_loc               <= i_curr_frame_loc;
            r_prev_loc               <= i_prev_frame_loc;
            o_busy                   <= 1'b1;
            o_bram_array_read_addr   <= make_addr(i_curr_frame_loc, '0);
            o_bram_array_read_enable <= sub_onehot('0);
            r_state                  <= S_RD_CURR;
          end
        end
        S_RD_CURR: begin
          o_bram_array_read_addr   <= make_addr(r_prev_loc, w_line);
          o_bram_array_read_enable <= sub_onehot(w_sub);
          r_state                  <= S_RD_PREV;
        end
        S_RD_PREV: begin
          r_hold                   <= w_bram_word;
          o_bram_array_read_enable <= '0;
          r_state                  <= S_LOAD;
        end
        S_LOAD: begin
          if (w_out_free) begin
            o_curr_data    <= r_hold;
            o_prev_data    <= w_bram_word;
            o_subimage_idx <= w_sub;
            o_line_idx     <= w_line;
            o_last_line    <= w_last_line;
            o_last         <= w_last;
            o_valid        <= 1'b1;
            if (w_last) begin
              r_state <= S_DONE;
            end else begin
              o_bram_array_read_addr   <= make_addr(r_curr_loc, w_next_line);
              o_bram_array_read_enable <= sub_onehot(w_next_sub);
              r_state                  <= S_RD_CURR;
            end
          end
        end
        S_DONE: begin
          if (o_valid && i_ready) begin
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gcbp_bram_reader.sv
`default_nettype none
// ============================================================================
// tb_gcbp_bram_reader : scoreboard bench with a behavioural 16-BRAM model.
//                                                     Revision: 1.0
// ============================================================================
module tb_gcbp_bram_reader;
  import gcbp_bram_reader_pkg::*;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_start;
  logic [1:0]    i_curr_frame_loc;
  logic [1:0]    i_prev_frame_loc;
  logic [8:0]    o_bram_array_read_addr;
  logic [15:0]   o_bram_array_read_enable;
  logic [2047:0] i_bram_array_read_data;
  logic [127:0]  o_curr_data;
  logic [127:0]  o_prev_data;
  logic [3:0]    o_subimage_idx;
  logic [5:0]    o_line_idx;
  logic          o_last_line;
  logic          o_last;
  logic          o_valid;
  logic          i_ready;
  logic          o_busy;
  logic          o_done;

  always #5 i_clk = ~i_clk;

  gcbp_bram_reader dut (
    .i_clk                    (i_clk),
    .i_reset                  (i_reset),
    .i_start                  (i_start),
    .i_curr_frame_loc         (i_curr_frame_loc),
    .i_prev_frame_loc         (i_prev_frame_loc),
    .o_bram_array_read_addr   (o_bram_array_read_addr),
    .o_bram_array_read_enable (o_bram_array_read_enable),
    .i_bram_array_read_data   (i_bram_array_read_data),
    .o_curr_data              (o_curr_data),
    .o_prev_data              (o_prev_data),
    .o_subimage_idx           (o_subimage_idx),
    .o_line_idx               (o_line_idx),
    .o_last_line              (o_last_line),
    .o_last                   (o_last),
    .o_valid                  (o_valid),
    .i_ready                  (i_ready),
    .o_busy                   (o_busy),
    .o_done                   (o_done)
  );

  typedef struct packed {
    logic [127:0] c;
    logic [127:0] p;
    logic [3:0]   s;
    logic [5:0]   l;
    logic         ll;
    logic         la;
  } beat_t;

  beat_t      exp_q[$];
  beat_t      got_b, exp_b, snap_b;
  logic       held;
  int         n_total = 0;
  int         n_bad   = 0;
  int         accept_cnt = 0;
  int         done_cnt   = 0;
  int         ready_mode = 0;
  int         stall_at   = -1;
  int         stall_left = 0;
  logic [1:0] exp_curr, exp_prev;
  int         trk_phase, trk_line, trk_sub;
  logic [8:0] trk_addr;

  function automatic logic [127:0] bram_word(input int k, input logic [8:0] a);
    return {32'(k), 23'h0, a, 32'(k * 1000) + 32'(a), 32'hFACE_0000 | 32'(a)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Behavioural BRAM array: 1-cycle latency, output held between enabled reads
  always @(posedge i_clk) begin
    for (int k = 0; k < 16; k++) begin
      if (o_bram_array_read_enable[k])
        i_bram_array_read_data[k*128 +: 128] <= bram_word(k, o_bram_array_read_addr);
    end
  end

  // Scoreboard monitor and stall-stability check
  always @(negedge i_clk) begin
    if (i_reset) begin
      held = 1'b0;
    end else begin
      if (o_done) done_cnt++;
      got_b = {o_curr_data, o_prev_data, o_subimage_idx, o_line_idx, o_last_line, o_last};
      if (o_valid && i_ready) begin
        n_total++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL beat_extra: got sub=%0d line=%0d want no beat", o_subimage_idx, o_line_idx);
        end else begin
          exp_b = exp_q.pop_front();
          if (got_b !== exp_b) begin
            n_bad++;
            $display("FAIL beat: got curr=%h prev=%h sub=%0d line=%0d ll=%b last=%b want curr=%h prev=%h sub=%0d line=%0d ll=%b last=%b",
                     got_b.c, got_b.p, got_b.s, got_b.l, got_b.ll, got_b.la,
                     exp_b.c, exp_b.p, exp_b.s, exp_b.l, exp_b.ll, exp_b.la);
          end
        end
        accept_cnt++;
      end
      if (o_valid && !i_ready) begin
        if (held) begin
          n_total++;
          if (got_b !== snap_b) begin
            n_bad++;
            $display("FAIL stall_stable: got sub=%0d line=%0d want sub=%0d line=%0d (fields changed)",
                     got_b.s, got_b.l, snap_b.s, snap_b.l);
          end
        end
        snap_b = got_b;
        held   = 1'b1;
      end else begin
        held = 1'b0;
      end
    end
  end

  // Read-address tracker: every enabled cycle must be the next curr/prev read
  always @(negedge i_clk) begin
    if (i_reset) begin
      trk_phase = 0; trk_line = 0; trk_sub = 0;
    end else if (|o_bram_array_read_enable) begin
      trk_addr = {(trk_phase == 0) ? exp_curr : exp_prev, 1'b0, 6'(trk_line)};
      check("rd_addr", 64'(o_bram_array_read_addr), 64'(trk_addr));
      check("rd_en", 64'(o_bram_array_read_enable), 64'(1) << trk_sub);
      if (trk_phase == 1) begin
        trk_phase = 0;
        if (trk_line == 63) begin
          trk_line = 0;
          trk_sub  = trk_sub + 1;
        end else begin
          trk_line = trk_line + 1;
        end
      end else begin
        trk_phase = 1;
      end
    end
  end

  // Ready driver: always-on or random, with an optional stall at one beat
  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge i_clk); #1;
      i_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stall_left > 0 && accept_cnt == stall_at) begin
        i_ready = 1'b0;
        if (o_valid) stall_left--;
      end
    end
  end

  task automatic start_pass(input logic [1:0] c, input logic [1:0] p);
    beat_t e;
    logic [8:0] a;
    @(posedge i_clk); #1;
    exp_curr = c; exp_prev = p;
    trk_phase = 0; trk_line = 0; trk_sub = 0;
    accept_cnt = 0; done_cnt = 0;
    for (int s = 0; s < 16; s++) begin
      for (int l = 0; l < 64; l++) begin
        a    = {c, 1'b0, 6'(l)};
        e.c  = bram_word(s, a);
        a    = {p, 1'b0, 6'(l)};
        e.p  = bram_word(s, a);
        e.s  = 4'(s);
        e.l  = 6'(l);
        e.ll = (l == 63);
        e.la = (s == 15) && (l == 63);
        exp_q.push_back(e);
      end
    end
    i_start = 1'b1; i_curr_frame_loc = c; i_prev_frame_loc = p;
    @(posedge i_clk); #1;
    i_start = 1'b0; i_curr_frame_loc = ~c; i_prev_frame_loc = ~p;
  endtask

  task automatic wait_done(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge i_clk);
      if (o_done) break;
    end
    check(name, 64'(i < budget), 64'(1));
  endtask

  task automatic wait_accept(input int n, input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge i_clk);
      if (accept_cnt >= n) break;
    end
    check(name, 64'(i < budget), 64'(1));
  endtask

  task automatic end_of_pass(input string tag);
    repeat (6) @(negedge i_clk);
    check({tag, "_done_count"}, 64'(done_cnt), 64'(1));
    check({tag, "_beat_count"}, 64'(accept_cnt), 64'(1024));
    check({tag, "_queue_left"}, 64'(exp_q.size()), 64'(0));
    check({tag, "_busy_low"}, 64'(o_busy), 64'(0));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 64'(o_valid), 64'(0));
    check({tag, "_busy"}, 64'(o_busy), 64'(0));
    check({tag, "_done"}, 64'(o_done), 64'(0));
    check({tag, "_en"}, 64'(o_bram_array_read_enable), 64'(0));
    check({tag, "_addr"}, 64'(o_bram_array_read_addr), 64'(0));
    check({tag, "_data"}, 64'(|{o_curr_data, o_prev_data}), 64'(0));
    check({tag, "_idx"}, 64'({o_subimage_idx, o_line_idx, o_last_line, o_last}), 64'(0));
    check({tag, "_state"}, 64'(dut.r_state), 64'(S_IDLE));
  endtask

  initial begin
    int cyc;
    i_reset = 1'b1; i_start = 1'b0;
    i_curr_frame_loc = 2'd0; i_prev_frame_loc = 2'd0;
    exp_curr = 2'd0; exp_prev = 2'd0;
    repeat (3) @(posedge i_clk);
    #1 i_reset = 1'b0;
    @(negedge i_clk);
    check_zero("reset");

    // Pass A: curr=1 prev=0, stall at beat 100, ignored mid-pass start
    ready_mode = 0; stall_at = 100; stall_left = 10;
    start_pass(2'd1, 2'd0);
    @(posedge i_clk); @(posedge i_clk); @(negedge i_clk);
    check("first_valid_early", 64'(o_valid), 64'(0));
    check("busy_set", 64'(o_busy), 64'(1));
    @(posedge i_clk); @(negedge i_clk);
    check("first_valid_rise", 64'(o_valid), 64'(1));
    wait_accept(300, 2000, "reach_beat300");
    @(posedge i_clk); #1;
    i_start = 1'b1; i_curr_frame_loc = 2'd2; i_prev_frame_loc = 2'd3;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    wait_done(6000, "passA_done_timeout");
    end_of_pass("passA");
    stall_at = -1;

    // Pass B: reset asserted mid-pass at beat 500
    start_pass(2'd2, 2'd1);
    wait_accept(500, 3000, "reach_beat500");
    @(posedge i_clk); #1 i_reset = 1'b1;
    @(posedge i_clk); #1 i_reset = 1'b0;
    exp_q.delete();
    @(negedge i_clk);
    check_zero("midreset");

    // Pass C: curr=3 prev=2, ready high, pass length
    start_pass(2'd3, 2'd2);
    cyc = 0;
    while (cyc < 4000) begin
      @(posedge i_clk); cyc++;
      @(negedge i_clk);
      if (o_done) break;
    end
    check("passC_cycles_in_range", 64'(cyc >= 3072 && cyc <= 3074), 64'(1));
    end_of_pass("passC");

    // Pass D: equal locations, random backpressure
    ready_mode = 1;
    start_pass(2'd0, 2'd0);
    wait_done(12000, "passD_done_timeout");
    end_of_pass("passD");
    ready_mode = 0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
